muldiv_ctrl: RTL

Sequencing controller for the EX-stage multiply/divide resources. It accepts one HILO arithmetic op (mult, multu, div, divu) from EX and drives the shared multiplier (fixed latency) and the iterative divider (start/ready handshake). It holds the EX stage via a stall request until the 64-bit {hi, lo} result is ready, then presents that result for exactly one cycle. It sits between EX decode and the `mul`/`div` instances and replaces ad-hoc per-unit stall logic with one FSM.

---
 rtl/muldiv_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one HILO op (mult/multu/div/divu) through the shared
// fixed-latency multiplier or the iterative divider. It stalls EX while the op
// is in flight and presents the registered 64-bit {hi, lo} result for one cycle.
// Optional feature macro: MULDIV_DIV0_FAST_EN. When it is defined, a divide by
// zero completes straight from IDLE with {op_a, 32'hFFFFFFFF} and the divider
// is never started.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [1:0]  op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stall_for_muldiv,
    output logic        res_valid,
    output logic [63:0] hilo_res
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [2:0] CNT_LAST = 3'(MUL_LAT - 1);

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  cnt;
    logic [63:0] res_q;
    logic        accept, div0_fast;

    assign accept = (state == IDLE) && op_valid && !flush;

`ifdef MULDIV_DIV0_FAST_EN
    assign div0_fast = accept && op_sel[1] && (op_b == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    // Next-state logic; flush overrides every transition back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div0_fast)      state_nxt = DONE;
                    else if (op_sel[1]) state_nxt = DIV;
                    else                state_nxt = MUL;
                end
            end
            MUL:  if (cnt == CNT_LAST) state_nxt = DONE;
            DIV:  if (div_ready) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State, operand latch, latency counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            cnt   <= 3'd0;
            res_q <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= op_sel;
                a_q  <= op_a;
                b_q  <= op_b;
            end
            // Counter idles at 0 outside MUL, so it always enters MUL at 0.
            if (flush || state != MUL) cnt <= 3'd0;
            else                       cnt <= cnt + 3'd1;
            if (!flush) begin
                if (div0_fast)
                    res_q <= {op_a, 32'hFFFF_FFFF};
                else if (state == MUL && cnt == CNT_LAST)
                    res_q <= mul_result;
                else if (state == DIV && div_ready)
                    res_q <= div_result;
            end
        end
    end

    // Unit drive, stall and result strobe; everything downstream uses latched operands.
    always_comb begin
        mul_signed       = 1'b0;
        mul_ina          = 32'd0;
        mul_inb          = 32'd0;
        div_start        = 1'b0;
        div_signed       = 1'b0;
        div_op1          = 32'd0;
        div_op2          = 32'd0;
        div_annul        = 1'b0;
        stall_for_muldiv = 1'b0;
        res_valid        = 1'b0;
        case (state)
            IDLE: stall_for_muldiv = op_valid && !rst;
            MUL: begin
                mul_signed       = (op_q == 2'b00);
                mul_ina          = a_q;
                mul_inb          = b_q;
                stall_for_muldiv = 1'b1;
            end
            DIV: begin
                div_start        = !div_ready;
                div_signed       = (op_q == 2'b10);
                div_op1          = a_q;
                div_op2          = b_q;
                stall_for_muldiv = 1'b1;
                // Reset clears the divider itself, so only flush needs an abort.
                div_annul        = flush && !rst;
            end
            DONE: res_valid = !flush;
            default: ;
        endcase
    end

    assign hilo_res = res_q;

endmodule
